// File: rtl/conware_pkg.sv
// Shared types and elaboration helpers for the conware grid loader.
// Pure declarations: no logic, no latency, no flow control.
package conware_pkg;

    localparam int CELL_BITS_DEF = 1;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int cell_index(input int row, input int col, input int width);
        return row * width + col;
    endfunction

endpackage

// File: rtl/grid_bank.sv
// One grid bank: lane-parallel beat write, flat read, full flag.
// Write lands on the clock edge; full flag set/clear is 1 cycle; no backpressure of its own.
module grid_bank #(
    parameter int DWIDTH    = 32,
    parameter int CELL_BITS = 1,
    parameter int NCELLS    = 1024,
    parameter int CNT_W     = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [CNT_W-1:0]            wr_beat,
    input  logic [DWIDTH-1:0]           wr_dat,
    input  logic                        set_full,
    input  logic                        clr_full,
    output logic [NCELLS*CELL_BITS-1:0] grid,
    output logic                        full
);

    localparam int CPB = DWIDTH / CELL_BITS;

    // Each cell has a fixed beat/lane origin, so lanes past the last cell simply have no home.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grid <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NCELLS; i++) begin
                if (wr_beat == CNT_W'(i / CPB))
                    grid[i*CELL_BITS +: CELL_BITS] <= wr_dat[(i % CPB)*CELL_BITS +: CELL_BITS];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            full <= 1'b0;
        else if (set_full)
            full <= 1'b1;
        else if (clr_full)
            full <= 1'b0;
    end

endmodule

// File: rtl/axis_grid_loader.sv
// AXI-Stream slave assembling packed beats into a flat cell grid, with ping-pong banks.
// out_valid 1 cycle after the final beat; TREADY low while the write bank is still full.
module axis_grid_loader
    import conware_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int CELL_BITS  = CELL_BITS_DEF,
    parameter int WIDTH      = 32,
    parameter int HEIGHT     = 32,
    parameter int DOUBLE_BUF = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DWIDTH-1:0]                S_AXIS_TDATA,
    input  logic                             S_AXIS_TVALID,
    input  logic                             S_AXIS_TLAST,
    output logic                             S_AXIS_TREADY,
    output logic [WIDTH*HEIGHT*CELL_BITS-1:0] out_grid,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             frame_err,
    output logic [15:0]                      frame_cnt
);

    localparam int CPB    = DWIDTH / CELL_BITS;
    localparam int NCELLS = WIDTH * HEIGHT;
    localparam int GW     = NCELLS * CELL_BITS;
    localparam int BEATS  = (NCELLS + CPB - 1) / CPB;
    localparam int CNT_W  = (clog2(BEATS) < 1) ? 1 : clog2(BEATS);
    localparam int NBANK  = (DOUBLE_BUF != 0) ? 2 : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   beat_cnt;
    logic               run;
    logic               wr_ptr, rd_ptr;
    logic               hs, wr_full, bank_we, commit, err, rd_release;
    logic [NBANK-1:0]   bank_full;
    logic [GW-1:0]      bank_grid [NBANK];

    assign wr_full       = wr_ptr ? bank_full[NBANK-1] : bank_full[0];
    // run holds TREADY low until the first edge after reset is released.
    assign S_AXIS_TREADY = run & ((state == ST_DRAIN) | ~wr_full);
    assign hs            = S_AXIS_TVALID & S_AXIS_TREADY;
    assign out_valid     = rd_ptr ? bank_full[NBANK-1] : bank_full[0];
    assign out_grid      = rd_ptr ? bank_grid[NBANK-1] : bank_grid[0];
    assign rd_release    = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bank_we   = 1'b0;
        commit    = 1'b0;
        err       = 1'b0;
        if (hs) begin
            if (state == ST_FILL) begin
                bank_we = 1'b1;
                if (beat_cnt == LAST_BEAT) begin
                    if (S_AXIS_TLAST) begin
                        commit = 1'b1;
                    end else begin
                        err       = 1'b1;
                        state_nxt = ST_DRAIN;
                    end
                end else if (S_AXIS_TLAST) begin
                    err = 1'b1;
                end
            end else if (S_AXIS_TLAST) begin
                state_nxt = ST_FILL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run       <= 1'b0;
            beat_cnt  <= '0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            run       <= 1'b1;
            frame_err <= err;
            if (commit)
                frame_cnt <= frame_cnt + 16'd1;
            if (hs && state == ST_FILL) begin
                if (beat_cnt == LAST_BEAT || S_AXIS_TLAST)
                    beat_cnt <= '0;
                else
                    beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // A commit and a release touch different banks, so both pointers may move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (NBANK == 2) begin
            if (commit)
                wr_ptr <= ~wr_ptr;
            if (rd_release)
                rd_ptr <= ~rd_ptr;
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic sel_wr, sel_rd;
        assign sel_wr = (wr_ptr == 1'(b));
        assign sel_rd = (rd_ptr == 1'(b));

        grid_bank #(
            .DWIDTH    (DWIDTH),
            .CELL_BITS (CELL_BITS),
            .NCELLS    (NCELLS),
            .CNT_W     (CNT_W)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (bank_we & sel_wr),
            .wr_beat  (beat_cnt),
            .wr_dat   (S_AXIS_TDATA),
            .set_full (commit & sel_wr),
            .clr_full (rd_release & sel_rd),
            .grid     (bank_grid[b]),
            .full     (bank_full[b])
        );
    end

endmodule

// File: tb/tb_axis_grid_loader.sv
// Bench for axis_grid_loader: 4x4 ping-pong instance and 3x3 single-bank instance.
module tb_axis_grid_loader;
    import conware_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  a_tdata = '0;
    logic        a_tvalid = 1'b0, a_tlast = 1'b0, a_oready = 1'b0;
    logic        a_tready, a_ovalid, a_err;
    logic [15:0] a_grid, a_cnt;

    logic [7:0]  b_tdata = '0;
    logic        b_tvalid = 1'b0, b_tlast = 1'b0, b_oready = 1'b0;
    logic        b_tready, b_ovalid, b_err;
    logic [8:0]  b_grid;
    logic [15:0] b_cnt;

    axis_grid_loader #(.DWIDTH(8), .CELL_BITS(1), .WIDTH(4), .HEIGHT(4), .DOUBLE_BUF(1)) dut_a (
        .clk(clk), .rst(rst), .S_AXIS_TDATA(a_tdata), .S_AXIS_TVALID(a_tvalid),
        .S_AXIS_TLAST(a_tlast), .S_AXIS_TREADY(a_tready), .out_grid(a_grid),
        .out_valid(a_ovalid), .out_ready(a_oready), .frame_err(a_err), .frame_cnt(a_cnt));

    axis_grid_loader #(.DWIDTH(8), .CELL_BITS(1), .WIDTH(3), .HEIGHT(3), .DOUBLE_BUF(0)) dut_b (
        .clk(clk), .rst(rst), .S_AXIS_TDATA(b_tdata), .S_AXIS_TVALID(b_tvalid),
        .S_AXIS_TLAST(b_tlast), .S_AXIS_TREADY(b_tready), .out_grid(b_grid),
        .out_valid(b_ovalid), .out_ready(b_oready), .frame_err(b_err), .frame_cnt(b_cnt));

    int total = 0, bad = 0;
    logic [15:0] a_exp_q[$], a_got_q[$];
    logic [8:0]  b_exp_q[$], b_got_q[$];
    int a_exp_err = 0, a_seen_err = 0, b_exp_err = 0, b_seen_err = 0;
    logic [15:0] a_exp_cnt = '0, b_exp_cnt = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_ovalid && a_oready) a_got_q.push_back(a_grid);
            if (b_ovalid && b_oready) b_got_q.push_back(b_grid);
            if (a_err) a_seen_err++;
            if (b_err) b_seen_err++;
        end
    end

    // Reference: cell (row,col) comes from beat i/8, lane i%8 of the frame.
    function automatic logic [15:0] ref_a(input logic [7:0] d[8]);
        logic [15:0] g;
        g = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                int i;
                i = cell_index(r, c, 4);
                g[i] = d[i/8][i%8];
            end
        return g;
    endfunction

    function automatic logic [8:0] ref_b(input logic [7:0] d[8]);
        logic [8:0] g;
        g = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                int i;
                i = cell_index(r, c, 3);
                g[i] = d[i/8][i%8];
            end
        return g;
    endfunction

    task automatic send_beat_a(input logic [7:0] d, input logic last);
        int w;
        a_tdata = d; a_tvalid = 1'b1; a_tlast = last;
        w = 0;
        @(negedge clk);
        while (!a_tready && w < 300) begin w++; @(negedge clk); end
        if (!a_tready) begin total++; bad++; $display("FAIL a_tready_timeout got=%b want=1", a_tready); end
        @(posedge clk); #1;
        a_tvalid = 1'b0; a_tlast = 1'b0;
    endtask

    task automatic send_beat_b(input logic [7:0] d, input logic last);
        int w;
        b_tdata = d; b_tvalid = 1'b1; b_tlast = last;
        w = 0;
        @(negedge clk);
        while (!b_tready && w < 300) begin w++; @(negedge clk); end
        if (!b_tready) begin total++; bad++; $display("FAIL b_tready_timeout got=%b want=1", b_tready); end
        @(posedge clk); #1;
        b_tvalid = 1'b0; b_tlast = 1'b0;
    endtask

    // A frame is good exactly when TLAST lands on beat BEATS (=2); anything else is one error.
    task automatic send_frame_a(input int n, input logic [7:0] d[8]);
        if (n == 2) begin a_exp_q.push_back(ref_a(d)); a_exp_cnt++; end
        else a_exp_err++;
        for (int k = 0; k < n; k++) send_beat_a(d[k], k == n - 1);
    endtask

    task automatic send_frame_b(input int n, input logic [7:0] d[8]);
        if (n == 2) begin b_exp_q.push_back(ref_b(d)); b_exp_cnt++; end
        else b_exp_err++;
        for (int k = 0; k < n; k++) send_beat_b(d[k], k == n - 1);
    endtask

    task automatic drain_a();
        a_oready = 1'b1;
        for (int c = 0; c < 200 && a_got_q.size() < a_exp_q.size(); c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drain_b();
        b_oready = 1'b1;
        for (int c = 0; c < 200 && b_got_q.size() < b_exp_q.size(); c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b want=0", a_tready); end
        total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL rst_ovalid got=%b want=0", a_ovalid); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", a_err); end
        total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%h want=0", a_cnt); end
        total++; if (a_grid !== 16'd0) begin bad++; $display("FAIL rst_grid got=%h want=0", a_grid); end
        rst = 1'b0;
        #2;
        total++; if (a_tready !== 1'b0) begin bad++; $display("FAIL rst_tready_pre_edge got=%b want=0", a_tready); end
        @(posedge clk); #1;
        total++; if (a_tready !== 1'b1) begin bad++; $display("FAIL rst_tready_up got=%b want=1", a_tready); end
        total++; if (b_tready !== 1'b1) begin bad++; $display("FAIL rst_b_tready_up got=%b want=1", b_tready); end
    endtask

    task automatic test_basic();
        a_oready = 1'b1;
        send_beat_a(8'hA5, 1'b0);
        total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", a_ovalid); end
        a_exp_q.push_back(16'h3CA5); a_exp_cnt++;
        send_beat_a(8'h3C, 1'b1);
        total++; if (a_ovalid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", a_ovalid); end
        total++; if (a_grid !== 16'h3CA5) begin bad++; $display("FAIL basic_grid got=%h want=3ca5", a_grid); end
        total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL basic_cnt got=%0d want=1", a_cnt); end
        @(posedge clk); #1;
        total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL basic_released got=%b want=0", a_ovalid); end
        drain_a();
        total++; if (a_got_q.size() != a_exp_q.size()) begin bad++; $display("FAIL basic_count got=%0d want=%0d", a_got_q.size(), a_exp_q.size()); end
        foreach (a_exp_q[i]) if (i < a_got_q.size()) begin total++; if (a_got_q[i] !== a_exp_q[i]) begin bad++; $display("FAIL basic_frame%0d got=%h want=%h", i, a_got_q[i], a_exp_q[i]); end end
        a_got_q.delete(); a_exp_q.delete();
    endtask

    task automatic test_pingpong();
        logic [7:0] f1[8], f2[8], f3[8];
        foreach (f1[k]) begin f1[k] = 8'($urandom); f2[k] = 8'($urandom); f3[k] = 8'($urandom); end
        a_oready = 1'b0;
        send_frame_a(2, f1);
        send_frame_a(2, f2);
        total++; if (a_tready !== 1'b0) begin bad++; $display("FAIL pp_full_tready got=%b want=0", a_tready); end
        total++; if (a_grid !== ref_a(f1)) begin bad++; $display("FAIL pp_first got=%h want=%h", a_grid, ref_a(f1)); end
        fork
            send_frame_a(2, f3);
            begin
                repeat (4) begin
                    @(negedge clk);
                    total++; if (a_tready !== 1'b0) begin bad++; $display("FAIL pp_stall got=%b want=0", a_tready); end
                end
                @(posedge clk); #1; a_oready = 1'b1;
                @(posedge clk); #1; a_oready = 1'b0;
                total++; if (a_ovalid !== 1'b1) begin bad++; $display("FAIL pp_no_gap got=%b want=1", a_ovalid); end
                total++; if (a_grid !== ref_a(f2)) begin bad++; $display("FAIL pp_second got=%h want=%h", a_grid, ref_a(f2)); end
                repeat (2) @(posedge clk);
                #1; a_oready = 1'b1;
            end
        join
        drain_a();
        total++; if (a_got_q.size() != a_exp_q.size()) begin bad++; $display("FAIL pp_count got=%0d want=%0d", a_got_q.size(), a_exp_q.size()); end
        foreach (a_exp_q[i]) if (i < a_got_q.size()) begin total++; if (a_got_q[i] !== a_exp_q[i]) begin bad++; $display("FAIL pp_frame%0d got=%h want=%h", i, a_got_q[i], a_exp_q[i]); end end
        total++; if (a_cnt !== a_exp_cnt) begin bad++; $display("FAIL pp_cnt got=%0d want=%0d", a_cnt, a_exp_cnt); end
        a_got_q.delete(); a_exp_q.delete();
    endtask

    task automatic test_short();
        logic [7:0] f[8], g[8];
        foreach (f[k]) begin f[k] = 8'($urandom); g[k] = 8'($urandom); end
        a_oready = 1'b1;
        send_frame_a(1, f);
        send_frame_a(2, g);
        drain_a();
        total++; if (a_seen_err != a_exp_err) begin bad++; $display("FAIL short_err got=%0d want=%0d", a_seen_err, a_exp_err); end
        total++; if (a_got_q.size() != a_exp_q.size()) begin bad++; $display("FAIL short_count got=%0d want=%0d", a_got_q.size(), a_exp_q.size()); end
        foreach (a_exp_q[i]) if (i < a_got_q.size()) begin total++; if (a_got_q[i] !== a_exp_q[i]) begin bad++; $display("FAIL short_frame%0d got=%h want=%h", i, a_got_q[i], a_exp_q[i]); end end
        total++; if (a_cnt !== a_exp_cnt) begin bad++; $display("FAIL short_cnt got=%0d want=%0d", a_cnt, a_exp_cnt); end
        a_got_q.delete(); a_exp_q.delete();
    endtask

    task automatic test_long();
        logic [7:0] g[8];
        foreach (g[k]) g[k] = 8'($urandom);
        a_oready = 1'b1;
        a_exp_err++;
        send_beat_a(8'($urandom), 1'b0);
        send_beat_a(8'($urandom), 1'b0);
        total++; if (a_err !== 1'b1) begin bad++; $display("FAIL long_err_pulse got=%b want=1", a_err); end
        send_beat_a(8'hFF, 1'b0);
        send_beat_a(8'hFF, 1'b1);
        total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL long_no_valid got=%b want=0", a_ovalid); end
        send_frame_a(2, g);
        drain_a();
        total++; if (a_seen_err != a_exp_err) begin bad++; $display("FAIL long_err got=%0d want=%0d", a_seen_err, a_exp_err); end
        total++; if (a_got_q.size() != a_exp_q.size()) begin bad++; $display("FAIL long_count got=%0d want=%0d", a_got_q.size(), a_exp_q.size()); end
        foreach (a_exp_q[i]) if (i < a_got_q.size()) begin total++; if (a_got_q[i] !== a_exp_q[i]) begin bad++; $display("FAIL long_frame%0d got=%h want=%h", i, a_got_q[i], a_exp_q[i]); end end
        total++; if (a_cnt !== a_exp_cnt) begin bad++; $display("FAIL long_cnt got=%0d want=%0d", a_cnt, a_exp_cnt); end
        a_got_q.delete(); a_exp_q.delete();
    endtask

    task automatic test_random();
        logic [7:0] f[8];
        bit done;
        done = 1'b0;
        fork
            begin
                for (int fr = 0; fr < 40; fr++) begin
                    int r, n;
                    r = $urandom_range(0, 9);
                    n = (r < 6) ? 2 : (r == 6) ? 1 : (r == 7) ? 3 : 4;
                    foreach (f[k]) f[k] = 8'($urandom);
                    send_frame_a(n, f);
                end
                done = 1'b1;
            end
            begin
                for (int c = 0; c < 5000 && !done; c++) begin
                    @(posedge clk); #1;
                    a_oready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain_a();
        total++; if (a_seen_err != a_exp_err) begin bad++; $display("FAIL rand_err got=%0d want=%0d", a_seen_err, a_exp_err); end
        total++; if (a_got_q.size() != a_exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", a_got_q.size(), a_exp_q.size()); end
        foreach (a_exp_q[i]) if (i < a_got_q.size()) begin total++; if (a_got_q[i] !== a_exp_q[i]) begin bad++; $display("FAIL rand_frame%0d got=%h want=%h", i, a_got_q[i], a_exp_q[i]); end end
        total++; if (a_cnt !== a_exp_cnt) begin bad++; $display("FAIL rand_cnt got=%0d want=%0d", a_cnt, a_exp_cnt); end
        a_got_q.delete(); a_exp_q.delete();
    endtask

    task automatic test_partial_b();
        logic [7:0] f[8];
        foreach (f[k]) f[k] = 8'($urandom);
        f[1] = 8'hFE | {7'd0, f[1][0]};
        b_oready = 1'b1;
        send_frame_b(2, f);
        total++; if (b_ovalid !== 1'b1) begin bad++; $display("FAIL partial_valid got=%b want=1", b_ovalid); end
        total++; if (b_grid !== ref_b(f)) begin bad++; $display("FAIL partial_grid got=%h want=%h", b_grid, ref_b(f)); end
        drain_b();
        total++; if (b_got_q.size() != b_exp_q.size()) begin bad++; $display("FAIL partial_count got=%0d want=%0d", b_got_q.size(), b_exp_q.size()); end
        foreach (b_exp_q[i]) if (i < b_got_q.size()) begin total++; if (b_got_q[i] !== b_exp_q[i]) begin bad++; $display("FAIL partial_frame%0d got=%h want=%h", i, b_got_q[i], b_exp_q[i]); end end
        b_got_q.delete(); b_exp_q.delete();
    endtask

    task automatic test_single_buf_b();
        logic [7:0] x[8], y[8];
        foreach (x[k]) begin x[k] = 8'($urandom); y[k] = 8'($urandom); end
        b_oready = 1'b0;
        send_frame_b(2, x);
        total++; if (b_tready !== 1'b0) begin bad++; $display("FAIL single_full_tready got=%b want=0", b_tready); end
        fork
            send_frame_b(2, y);
            begin
                repeat (3) begin
                    @(negedge clk);
                    total++; if (b_tready !== 1'b0) begin bad++; $display("FAIL single_stall got=%b want=0", b_tready); end
                end
                @(posedge clk); #1; b_oready = 1'b1;
                @(posedge clk); #1; b_oready = 1'b0;
                total++; if (b_tready !== 1'b1) begin bad++; $display("FAIL single_tready_after_release got=%b want=1", b_tready); end
                total++; if (b_ovalid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%b want=0", b_ovalid); end
                repeat (3) @(posedge clk);
                #1; b_oready = 1'b1;
            end
        join
        drain_b();
        total++; if (b_got_q.size() != b_exp_q.size()) begin bad++; $display("FAIL single_count got=%0d want=%0d", b_got_q.size(), b_exp_q.size()); end
        foreach (b_exp_q[i]) if (i < b_got_q.size()) begin total++; if (b_got_q[i] !== b_exp_q[i]) begin bad++; $display("FAIL single_frame%0d got=%h want=%h", i, b_got_q[i], b_exp_q[i]); end end
        total++; if (b_cnt !== b_exp_cnt) begin bad++; $display("FAIL single_cnt got=%0d want=%0d", b_cnt, b_exp_cnt); end
        total++; if (b_seen_err != b_exp_err) begin bad++; $display("FAIL single_err got=%0d want=%0d", b_seen_err, b_exp_err); end
        b_got_q.delete(); b_exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [7:0] f[8], g[8];
        foreach (f[k]) begin f[k] = 8'($urandom); g[k] = 8'($urandom); end
        a_oready = 1'b0;
        send_frame_a(2, f);
        total++; if (a_ovalid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid got=%b want=1", a_ovalid); end
        send_beat_a(8'($urandom), 1'b0);
        #3 rst = 1'b1;
        #1;
        total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", a_ovalid); end
        total++; if (a_grid !== 16'd0) begin bad++; $display("FAIL rmid_grid got=%h want=0", a_grid); end
        total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL rmid_cnt got=%h want=0", a_cnt); end
        total++; if (a_tready !== 1'b0) begin bad++; $display("FAIL rmid_tready got=%b want=0", a_tready); end
        a_exp_q.delete(); a_got_q.delete();
        a_exp_cnt = '0; a_exp_err = 0; a_seen_err = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        a_oready = 1'b1;
        send_frame_a(2, g);
        drain_a();
        total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL rmid_cnt_after got=%0d want=1", a_cnt); end
        total++; if (a_got_q.size() != a_exp_q.size()) begin bad++; $display("FAIL rmid_count got=%0d want=%0d", a_got_q.size(), a_exp_q.size()); end
        foreach (a_exp_q[i]) if (i < a_got_q.size()) begin total++; if (a_got_q[i] !== a_exp_q[i]) begin bad++; $display("FAIL rmid_frame%0d got=%h want=%h", i, a_got_q[i], a_exp_q[i]); end end
        total++; if (a_seen_err != a_exp_err) begin bad++; $display("FAIL rmid_err got=%0d want=%0d", a_seen_err, a_exp_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pingpong();
        test_short();
        test_long();
        test_random();
        test_partial_b();
        test_single_buf_b();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
